// File: rtl/ir_line_classifier_if.sv
// ---------------------------------------------------------------------------
// ir_line_classifier_if
// Bundle of signals between the sensor/navigation side (master) and the IR
// line classifier (slave).
//   master drives : ttd_valid, ttd_bus, cal_start
//   slave drives  : cal_busy, cal_done, calibrated, threshold, ir_color,
//                   left_sum, right_sum, on_track, lost, pos_ok, left, right,
//                   flags_valid
// ---------------------------------------------------------------------------
interface ir_line_classifier_if #(
  parameter int WIDTH = 17
);
  logic                 ttd_valid;
  logic [8*WIDTH-1:0]   ttd_bus;
  logic                 cal_start;
  logic                 cal_busy;
  logic                 cal_done;
  logic                 calibrated;
  logic [WIDTH-1:0]     threshold;
  logic [7:0]           ir_color;
  logic [2:0]           left_sum;
  logic [2:0]           right_sum;
  logic                 on_track;
  logic                 lost;
  logic                 pos_ok;
  logic                 left;
  logic                 right;
  logic                 flags_valid;

  modport master (
    output ttd_valid, ttd_bus, cal_start,
    input  cal_busy, cal_done, calibrated, threshold, ir_color, left_sum,
           right_sum, on_track, lost, pos_ok, left, right, flags_valid
  );

  modport slave (
    input  ttd_valid, ttd_bus, cal_start,
    output cal_busy, cal_done, calibrated, threshold, ir_color, left_sum,
           right_sum, on_track, lost, pos_ok, left, right, flags_valid
  );
endinterface

// File: rtl/ir_line_classifier.sv
// ---------------------------------------------------------------------------
// ir_line_classifier
// Calibrates a black/white threshold from the darkest and brightest channels
// of the 8-channel IR sensor, then classifies each scan into colour bits,
// per-side black counts and sample-synchronously filtered pattern flags.
// Ports:
//   WF_CLK  - system clock, rising edge
//   reset   - synchronous active-high reset
//   sif     - slave side of ir_line_classifier_if (scan input, calibration
//             request, threshold/colour/flag outputs)
// Pipeline in RUN: scan captured at edge t, classified at t+1, filtered
// flags and flags_valid at t+2.
// ---------------------------------------------------------------------------
module ir_line_classifier #(
  parameter int WIDTH       = 17,
  parameter int CAL_SAMPLES = 16,
  parameter int FILT        = 4
) (
  input  logic                  WF_CLK,
  input  logic                  reset,
  ir_line_classifier_if.slave   sif
);

  localparam int                CW        = $clog2(CAL_SAMPLES + 1);
  localparam int                FW        = $clog2(FILT + 1);
  localparam logic [CW-1:0]     CAL_LAST  = CW'(CAL_SAMPLES);
  localparam logic [FW-1:0]     FILT_LAST = FW'(FILT - 1);
  localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};

  // Flag slots: 0 on_track, 1 lost, 2 pos_ok, 3 left, 4 right
  localparam logic [4:0]        FLAGS_RST = 5'b00010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAL  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  function automatic logic [WIDTH-1:0] bus_min(input logic [8*WIDTH-1:0] bus);
    logic [WIDTH-1:0] m;
    m = bus[0 +: WIDTH];
    for (int n = 1; n < 8; n++) begin
      m = (bus[n*WIDTH +: WIDTH] < m) ? bus[n*WIDTH +: WIDTH] : m;
    end
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] bus_max(input logic [8*WIDTH-1:0] bus);
    logic [WIDTH-1:0] m;
    m = bus[0 +: WIDTH];
    for (int n = 1; n < 8; n++) begin
      m = (bus[n*WIDTH +: WIDTH] > m) ? bus[n*WIDTH +: WIDTH] : m;
    end
    return m;
  endfunction

  function automatic logic [2:0] ones4(input logic [3:0] b);
    return {2'b00, b[0]} + {2'b00, b[1]} + {2'b00, b[2]} + {2'b00, b[3]};
  endfunction

  state_e              r_state;
  state_e              w_next_state;
  logic                w_cal_busy;
  logic                w_finish;
  logic                w_cal_full;
  logic                w_run_ok;

  logic [WIDTH-1:0]    r_run_min;
  logic [WIDTH-1:0]    r_run_max;
  logic [CW-1:0]       r_cal_cnt;
  logic [WIDTH-1:0]    w_smp_min;
  logic [WIDTH-1:0]    w_smp_max;
  logic [WIDTH+1:0]    w_thr_wide;

  logic [WIDTH-1:0]    r_threshold;
  logic                r_cal_done;
  logic                r_calibrated;

  logic                r_s1_valid;
  logic [8*WIDTH-1:0]  r_s1_bus;
  logic [7:0]          w_color;
  logic [7:0]          r_ir_color;
  logic [2:0]          r_left_sum;
  logic [2:0]          r_right_sum;
  logic                r_s2_valid;

  logic [4:0]          w_raw;
  logic [4:0]          r_filt;
  logic [FW-1:0]       r_fcnt [5];
  logic                r_flags_valid;

  assign w_cal_full = (r_cal_cnt == CAL_LAST);
  // A cal_start in RUN freezes the pipeline on that very edge.
  assign w_run_ok   = (r_state == ST_RUN) && !sif.cal_start;
  assign w_smp_min  = bus_min(sif.ttd_bus);
  assign w_smp_max  = bus_max(sif.ttd_bus);
  // 3*min + max in WIDTH+2 bits, then divide by 4
  assign w_thr_wide = ({2'b00, r_run_min} << 1) + {2'b00, r_run_min} + {2'b00, r_run_max};

  // FSM state register
  always_ff @(posedge WF_CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic; cal_start wins over everything, including the final sample
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (sif.cal_start) w_next_state = ST_CAL;
        else               w_next_state = ST_IDLE;
      end
      ST_CAL: begin
        if (sif.cal_start)    w_next_state = ST_CAL;
        else if (w_cal_full)  w_next_state = ST_RUN;
        else                  w_next_state = ST_CAL;
      end
      ST_RUN: begin
        if (sif.cal_start) w_next_state = ST_CAL;
        else               w_next_state = ST_RUN;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag and the edge on which a new threshold loads
  always_comb begin
    w_cal_busy = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      ST_CAL: begin
        w_cal_busy = 1'b1;
        w_finish   = w_cal_full && !sif.cal_start;
      end
      ST_IDLE, ST_RUN: begin
        w_cal_busy = 1'b0;
        w_finish   = 1'b0;
      end
      default: begin
        w_cal_busy = 1'b0;
        w_finish   = 1'b0;
      end
    endcase
  end

  // Calibration accumulator: running min/max and absorbed sample count
  always_ff @(posedge WF_CLK) begin
    if (reset || sif.cal_start) begin
      r_run_min <= ALL_ONES;
      r_run_max <= {WIDTH{1'b0}};
      r_cal_cnt <= {CW{1'b0}};
    end else if ((r_state == ST_CAL) && sif.ttd_valid && !w_cal_full) begin
      r_run_min <= (w_smp_min < r_run_min) ? w_smp_min : r_run_min;
      r_run_max <= (w_smp_max > r_run_max) ? w_smp_max : r_run_max;
      r_cal_cnt <= r_cal_cnt + CW'(1);
    end else begin
      r_run_min <= r_run_min;
      r_run_max <= r_run_max;
      r_cal_cnt <= r_cal_cnt;
    end
  end

  // Threshold load and calibration status
  always_ff @(posedge WF_CLK) begin
    if (reset) begin
      r_threshold  <= ALL_ONES;
      r_cal_done   <= 1'b0;
      r_calibrated <= 1'b0;
    end else if (w_finish) begin
      r_threshold  <= w_thr_wide[WIDTH+1:2];
      r_cal_done   <= 1'b1;
      r_calibrated <= 1'b1;
    end else begin
      r_threshold  <= r_threshold;
      r_cal_done   <= 1'b0;
      r_calibrated <= r_calibrated;
    end
  end

  // Stage 1: capture a RUN scan
  always_ff @(posedge WF_CLK) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_bus   <= {(8*WIDTH){1'b0}};
    end else if (w_run_ok && sif.ttd_valid) begin
      r_s1_valid <= 1'b1;
      r_s1_bus   <= sif.ttd_bus;
    end else begin
      r_s1_valid <= 1'b0;
      r_s1_bus   <= r_s1_bus;
    end
  end

  // Per-channel black test; a value equal to the threshold is white
  always_comb begin
    w_color = 8'h00;
    for (int n = 0; n < 8; n++) begin
      w_color[n] = (r_s1_bus[n*WIDTH +: WIDTH] > r_threshold);
    end
  end

  // Stage 2: register colour bits and per-side black counts
  always_ff @(posedge WF_CLK) begin
    if (reset) begin
      r_ir_color  <= 8'h00;
      r_left_sum  <= 3'd0;
      r_right_sum <= 3'd0;
      r_s2_valid  <= 1'b0;
    end else if (w_run_ok && r_s1_valid) begin
      r_ir_color  <= w_color;
      r_left_sum  <= ones4(w_color[7:4]);
      r_right_sum <= ones4(w_color[3:0]);
      r_s2_valid  <= 1'b1;
    end else begin
      r_ir_color  <= r_ir_color;
      r_left_sum  <= r_left_sum;
      r_right_sum <= r_right_sum;
      r_s2_valid  <= 1'b0;
    end
  end

  // Raw pattern flags from the registered colour bits
  always_comb begin
    w_raw    = 5'b00000;
    w_raw[0] = r_ir_color[3] | r_ir_color[4];
    w_raw[1] = (r_ir_color == 8'h00);
    // Mirror symmetry: c7/c6/c5 must match c0/c1/c2
    w_raw[2] = (r_ir_color[3] | r_ir_color[4]) &
               (r_ir_color[7:5] == {r_ir_color[0], r_ir_color[1], r_ir_color[2]});
    w_raw[3] = &r_ir_color[7:4];
    w_raw[4] = &r_ir_color[3:0];
  end

  // Stage 3: per-flag disagreement counters and filtered flags
  always_ff @(posedge WF_CLK) begin
    if (reset) begin
      r_filt        <= FLAGS_RST;
      r_flags_valid <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        r_fcnt[k] <= {FW{1'b0}};
      end
    end else if (w_run_ok && r_s2_valid) begin
      r_flags_valid <= 1'b1;
      for (int k = 0; k < 5; k++) begin
        if (w_raw[k] != r_filt[k]) begin
          // Counter never passes FILT-1: the FILT-th disagreement flips and clears
          if (r_fcnt[k] >= FILT_LAST) begin
            r_filt[k] <= w_raw[k];
            r_fcnt[k] <= {FW{1'b0}};
          end else begin
            r_filt[k] <= r_filt[k];
            r_fcnt[k] <= r_fcnt[k] + FW'(1);
          end
        end else begin
          r_filt[k] <= r_filt[k];
          r_fcnt[k] <= {FW{1'b0}};
        end
      end
    end else begin
      r_filt        <= r_filt;
      r_flags_valid <= 1'b0;
      for (int k = 0; k < 5; k++) begin
        r_fcnt[k] <= r_fcnt[k];
      end
    end
  end

  assign sif.cal_busy    = w_cal_busy;
  assign sif.cal_done    = r_cal_done;
  assign sif.calibrated  = r_calibrated;
  assign sif.threshold   = r_threshold;
  assign sif.ir_color    = r_ir_color;
  assign sif.left_sum    = r_left_sum;
  assign sif.right_sum   = r_right_sum;
  assign sif.on_track    = r_filt[0];
  assign sif.lost        = r_filt[1];
  assign sif.pos_ok      = r_filt[2];
  assign sif.left        = r_filt[3];
  assign sif.right       = r_filt[4];
  assign sif.flags_valid = r_flags_valid;

endmodule

// File: tb/tb_ir_line_classifier.sv
module tb_ir_line_classifier;
  localparam int W    = 17;
  localparam int NCAL = 16;
  localparam int NF   = 4;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ir_line_classifier_if #(.WIDTH(W)) sif ();
  ir_line_classifier #(.WIDTH(W), .CAL_SAMPLES(NCAL), .FILT(NF)) dut (
    .WF_CLK (clk),
    .reset  (rst),
    .sif    (sif)
  );

  int total = 0;
  int bad   = 0;

  // Observed flags: {on_track, lost, pos_ok, left, right}
  wire [4:0]  fl   = {sif.on_track, sif.lost, sif.pos_ok, sif.left, sif.right};
  wire [3:0]  stat = {sif.cal_busy, sif.cal_done, sif.calibrated, sif.flags_valid};
  wire [22:0] snap = {sif.ir_color, sif.left_sum, sif.right_sum, fl, stat};
  localparam logic [22:0] RST_SNAP = {8'h00, 3'd0, 3'd0, 5'b01000, 4'b0000};

  typedef struct { int due; logic [13:0] val; } ent_t;
  ent_t       cq[$];
  ent_t       fq[$];
  logic [4:0] hist[$];
  logic [4:0] filt_m;

  function automatic logic [8*W-1:0] pat(input logic [7:0] blk, input int hi, input int lo);
    logic [8*W-1:0] r;
    for (int n = 0; n < 8; n++) r[n*W +: W] = blk[n] ? W'(hi) : W'(lo);
    return r;
  endfunction

  // Flags a scan should raise, written straight from the pattern rules
  function automatic logic [4:0] raw_of(input logic [7:0] c);
    logic on;
    on = c[3] || c[4];
    return {on, c == 8'h00, on && c[7] == c[0] && c[6] == c[1] && c[5] == c[2],
            c[7:4] == 4'hF, c[3:0] == 4'hF};
  endfunction

  // A flag follows raw once the last NF classified samples all disagreed with it
  function automatic void model_push(input logic [4:0] raw);
    logic all_dis;
    hist.push_back(raw);
    if (hist.size() > NF) void'(hist.pop_front());
    for (int f = 0; f < 5; f++) begin
      all_dis = (hist.size() == NF);
      for (int j = 0; j < hist.size(); j++) if (hist[j][f] == filt_m[f]) all_dis = 0;
      if (all_dis) filt_m[f] = raw[f];
    end
  endfunction

  task automatic step(input logic v, input logic [8*W-1:0] b, input logic cs);
    sif.ttd_valid = v;
    sif.ttd_bus   = b;
    sif.cal_start = cs;
    @(posedge clk);
    @(negedge clk);
    sif.ttd_valid = 1'b0;
    sif.cal_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(0, '0, 0);
    step(0, '0, 0);
    rst = 1'b0;
    total++; if (snap !== RST_SNAP) begin bad++; $display("FAIL reset_state got=%h exp=%h", snap, RST_SNAP); end
    total++; if (sif.threshold !== ONES) begin bad++; $display("FAIL reset_thr got=%0d exp=%0d", sif.threshold, ONES); end
    for (int i = 0; i < 5; i++) begin
      step(1, pat(8'($urandom), 50000, 10), 0);
      total++; if ({snap, sif.threshold} !== {RST_SNAP, ONES}) begin
        bad++; $display("FAIL idle_ignore got=%h exp=%h", {snap, sif.threshold}, {RST_SNAP, ONES});
      end
    end
  endtask

  task automatic test_calibration;
    logic [8*W-1:0] b;
    step(0, '0, 1);
    total++; if (stat !== 4'b1000) begin bad++; $display("FAIL cal_enter got=%b exp=1000", stat); end
    for (int s = 0; s < NCAL; s++) begin
      if ($urandom_range(0, 1) == 1) step(0, '0, 0);
      b = pat(8'hFE, 2000, 400);
      if (s == 6) b[5*W +: W] = W'(8000);
      step(1, b, 0);
      total++; if (stat !== 4'b1000) begin bad++; $display("FAIL cal_busy s=%0d got=%b exp=1000", s, stat); end
    end
    step(0, '0, 0);
    total++; if ({stat, sif.threshold} !== {4'b0110, W'(2300)}) begin
      bad++; $display("FAIL cal_done got=%b thr=%0d exp=0110 thr=2300", stat, sif.threshold);
    end
    step(0, '0, 0);
    total++; if (stat !== 4'b0010) begin bad++; $display("FAIL cal_pulse got=%b exp=0010", stat); end
  endtask

  task automatic test_classify;
    logic [8*W-1:0] p, q;
    p = pat(8'h18, 3000, 1000);
    step(1, p, 0);
    total++; if (snap !== {8'h00, 3'd0, 3'd0, 5'b01000, 4'b0010}) begin bad++; $display("FAIL cls_lat0 got=%h", snap); end
    step(0, p, 0);
    total++; if ({sif.ir_color, sif.left_sum, sif.right_sum, sif.flags_valid} !== {8'h18, 3'd1, 3'd1, 1'b0}) begin
      bad++; $display("FAIL cls_color got=%h/%0d/%0d fv=%b exp=18/1/1 fv=0", sif.ir_color, sif.left_sum, sif.right_sum, sif.flags_valid);
    end
    step(0, p, 0);
    total++; if ({fl, sif.flags_valid} !== {5'b01000, 1'b1}) begin bad++; $display("FAIL cls_first got=%b fv=%b exp=01000 fv=1", fl, sif.flags_valid); end
    for (int k = 0; k < 6; k++) begin
      step(k < 3, p, 0);
      if (k == 3) begin
        total++; if ({fl, sif.flags_valid} !== {5'b01000, 1'b1}) begin bad++; $display("FAIL cls_third got=%b exp=01000", fl); end
      end else if (k == 4) begin
        total++; if ({fl, sif.flags_valid} !== {5'b10100, 1'b1}) begin bad++; $display("FAIL cls_fourth got=%b exp=10100", fl); end
      end else if (k == 5) begin
        total++; if (sif.flags_valid !== 1'b0) begin bad++; $display("FAIL cls_fv_end got=%b exp=0", sif.flags_valid); end
      end
    end
    q = p; q[0 +: W] = W'(2300);
    step(1, q, 0); step(0, q, 0);
    total++; if (sif.ir_color !== 8'h18) begin bad++; $display("FAIL cls_equal got=%h exp=18", sif.ir_color); end
    q[0 +: W] = W'(2301);
    step(1, q, 0); step(0, q, 0);
    total++; if (sif.ir_color !== 8'h19) begin bad++; $display("FAIL cls_above got=%h exp=19", sif.ir_color); end
    step(1, p, 0); step(0, p, 0); step(0, p, 0);
    total++; if (fl !== 5'b10100) begin bad++; $display("FAIL cls_settle got=%b exp=10100", fl); end
  endtask

  task automatic test_filter;
    logic [8*W-1:0] p, l;
    p = pat(8'h18, 3000, 1000);
    l = pat(8'h00, 3000, 1000);
    for (int k = 0; k < 10; k++) begin
      step(k < 8, (k % 2 == 0) ? l : p, 0);
      total++; if (fl !== 5'b10100) begin bad++; $display("FAIL filt_alt k=%0d got=%b exp=10100", k, fl); end
    end
    for (int k = 0; k < 6; k++) begin
      step(k < 4, (k < 3) ? l : p, 0);
      total++; if (fl !== 5'b10100) begin bad++; $display("FAIL filt_3lost k=%0d got=%b exp=10100", k, fl); end
    end
    for (int k = 0; k < 7; k++) begin
      step(k < 4, l, 0);
      if (k == 4) begin
        total++; if (fl !== 5'b10100) begin bad++; $display("FAIL filt_early got=%b exp=10100", fl); end
      end else if (k == 5) begin
        total++; if ({fl, sif.flags_valid} !== {5'b01000, 1'b1}) begin bad++; $display("FAIL filt_lost got=%b fv=%b exp=01000 fv=1", fl, sif.flags_valid); end
      end
    end
  endtask

  task automatic test_right;
    logic [8*W-1:0] r;
    r = pat(8'h0F, 3000, 1000);
    for (int k = 0; k < 6; k++) begin
      step(k < 4, r, 0);
      if (k == 4) begin
        total++; if (fl !== 5'b01000) begin bad++; $display("FAIL right_early got=%b exp=01000", fl); end
      end else if (k == 5) begin
        total++; if ({fl, sif.ir_color, sif.left_sum, sif.right_sum} !== {5'b10001, 8'h0F, 3'd0, 3'd4}) begin
          bad++; $display("FAIL right_set got=%b %h %0d %0d exp=10001 0f 0 4", fl, sif.ir_color, sif.left_sum, sif.right_sum);
        end
      end
    end
  endtask

  task automatic test_recal;
    logic [8*W-1:0] b;
    int mn, mx, v, thr;
    step(0, '0, 1);
    for (int s = 0; s < NCAL; s++) begin
      for (int n = 0; n < 8; n++) b[n*W +: W] = W'($urandom_range(10, 50));
      step(1, b, s == NCAL - 1);
      total++; if ({stat, fl, sif.threshold} !== {4'b1010, 5'b10001, W'(2300)}) begin
        bad++; $display("FAIL recal_hold1 s=%0d got=%b %b %0d exp=1010 10001 2300", s, stat, fl, sif.threshold);
      end
    end
    mn = 1 << 30; mx = 0;
    for (int s = 0; s < NCAL; s++) begin
      for (int n = 0; n < 8; n++) begin
        v = $urandom_range(100, 900);
        b[n*W +: W] = W'(v);
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
      step(1, b, 0);
      total++; if ({stat, fl, sif.threshold} !== {4'b1010, 5'b10001, W'(2300)}) begin
        bad++; $display("FAIL recal_hold2 s=%0d got=%b %b %0d exp=1010 10001 2300", s, stat, fl, sif.threshold);
      end
    end
    thr = (3 * mn + mx) / 4;
    step(0, '0, 0);
    total++; if ({stat, fl, sif.threshold} !== {4'b0110, 5'b10001, W'(thr)}) begin
      bad++; $display("FAIL recal_done got=%b %b %0d exp=0110 10001 %0d", stat, fl, sif.threshold, thr);
    end
  endtask

  task automatic test_reset_midcal;
    step(0, '0, 1);
    for (int s = 0; s < 5; s++) step(1, pat(8'h0F, 3000, 50), 0);
    rst = 1'b1;
    step(1, pat(8'h0F, 3000, 50), 0);
    rst = 1'b0;
    total++; if ({snap, sif.threshold} !== {RST_SNAP, ONES}) begin
      bad++; $display("FAIL midcal_reset got=%h exp=%h", {snap, sif.threshold}, {RST_SNAP, ONES});
    end
  endtask

  task automatic test_random;
    logic [8*W-1:0] b;
    logic [7:0] c, blk;
    logic v, fv_exp;
    int mn, mx, x, thr;
    logic [7:0] pats [8] = '{8'h00, 8'h18, 8'h0F, 8'hF0, 8'hFF, 8'h3C, 8'h81, 8'h08};
    rst = 1'b1; step(0, '0, 0); rst = 1'b0;
    hist.delete(); cq.delete(); fq.delete();
    filt_m = 5'b01000;
    step(0, '0, 1);
    mn = 1 << 30; mx = 0;
    for (int s = 0; s < NCAL; s++) begin
      for (int n = 0; n < 8; n++) begin
        x = $urandom_range(2000, 120000);
        b[n*W +: W] = W'(x);
        if (x < mn) mn = x;
        if (x > mx) mx = x;
      end
      step(1, b, 0);
    end
    thr = (3 * mn + mx) / 4;
    step(0, '0, 0);
    total++; if (sif.threshold !== W'(thr)) begin bad++; $display("FAIL rnd_thr got=%0d exp=%0d", sif.threshold, thr); end
    blk = 8'h00;
    for (int i = 0; i < 403; i++) begin
      v = (i < 400) && ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 3) blk = ($urandom_range(0, 7) == 7) ? 8'($urandom) : pats[$urandom_range(0, 6)];
      c = 8'h00;
      for (int n = 0; n < 8; n++) begin
        x = blk[n] ? thr + 1 + $urandom_range(0, 50) : thr - $urandom_range(0, 50);
        b[n*W +: W] = W'(x);
        c[n] = (x > thr);
      end
      if (v) begin
        cq.push_back('{i + 1, {c, 3'($countones(c[7:4])), 3'($countones(c[3:0]))}});
        model_push(raw_of(c));
        fq.push_back('{i + 2, {9'd0, filt_m}});
      end
      step(v, b, 0);
      if (cq.size() > 0 && cq[0].due == i) begin
        total++; if ({sif.ir_color, sif.left_sum, sif.right_sum} !== cq[0].val) begin
          bad++; $display("FAIL rnd_color i=%0d got=%h exp=%h", i, {sif.ir_color, sif.left_sum, sif.right_sum}, cq[0].val);
        end
        void'(cq.pop_front());
      end
      fv_exp = (fq.size() > 0 && fq[0].due == i);
      total++; if (sif.flags_valid !== fv_exp) begin bad++; $display("FAIL rnd_fv i=%0d got=%b exp=%b", i, sif.flags_valid, fv_exp); end
      if (fv_exp) begin
        total++; if (fl !== fq[0].val[4:0]) begin bad++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i, fl, fq[0].val[4:0]); end
        void'(fq.pop_front());
      end
    end
  endtask

  initial begin
    sif.ttd_valid = 1'b0;
    sif.ttd_bus   = '0;
    sif.cal_start = 1'b0;
    test_reset();
    test_calibration();
    test_classify();
    test_filter();
    test_right();
    test_recal();
    test_reset_midcal();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
